tgl_handshake_rx: RTL and testbench

Receiving end of the team's two-phase (toggle) request/acknowledge link. The transmitter signals each new word by flipping REQ_TGL, using a toggle flip-flop with T pulsed once per word. This block:
- synchronizes REQ_TGL into the CLK domain;
- detects the level change and captures DATA_IN;
- presents the word on a valid/ready port;
- flips ACK_TGL once the word is consumed.
It sits at the destination side of clock-domain crossings and slow-peripheral links.

---
 rtl/tgl_hs_pkg.sv | 12 +
 rtl/tgl_sync.sv | 25 ++
 rtl/tgl_handshake_rx.sv | 104 ++++++++++
 tb/tb_tgl_handshake_rx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tgl_hs_pkg.sv
// Shared types and default sizes for the two-phase (toggle) request/acknowledge link.
package tgl_hs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/tgl_sync.sv
// Flop-chain synchronizer for a single toggle level; shared by the link's rx and tx ends.
// Latency: SYNC_STAGES cycles from d to q.
// Backpressure: none; q simply tracks d delayed.
module tgl_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge CLK) begin
        if (RST) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/tgl_handshake_rx.sv
// Receive end of the toggle req/ack link: sync REQ_TGL, capture DATA_IN, offer it valid/ready, flip ACK_TGL on consume.
// Latency: DOUT_VALID rises SYNC_STAGES+1 edges after REQ_TGL flips; ACK_TGL flips on the accepting edge.
// Backpressure: DOUT held while DOUT_READY=0; ACK withheld, so the transmitter stalls. TGL_RX_OVR_EN adds OVR_CNT.
module tgl_handshake_rx
    import tgl_hs_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef TGL_RX_OVR_EN
    ,
    parameter int CNT_W       = 8
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_TGL,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic              ACK_TGL
`ifdef TGL_RX_OVR_EN
    ,
    output logic [CNT_W-1:0]  OVR_CNT
`endif
);

    state_t state;
    state_t state_nxt;
    logic   req_sync;
    logic   req_seen;
    logic   pending;
    logic   capture;
    logic   consume;

    tgl_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_req_sync (
        .CLK(CLK),
        .RST(RST),
        .d  (REQ_TGL),
        .q  (req_sync)
    );

    assign pending    = req_sync ^ req_seen;
    assign DOUT_VALID = (state == HOLD);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        consume   = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (DOUT_READY) begin
                    consume   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // req_seen only advances on capture, so flips during HOLD stay pending (odd) or cancel (even).
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            req_seen <= 1'b0;
            ACK_TGL  <= 1'b0;
            DOUT     <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                DOUT     <= DATA_IN;
                req_seen <= req_sync;
            end
            if (consume) begin
                ACK_TGL <= ~ACK_TGL;
            end
        end
    end

`ifdef TGL_RX_OVR_EN
    logic req_sync_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            req_sync_d <= 1'b0;
            OVR_CNT    <= '0;
        end else begin
            req_sync_d <= req_sync;
            if ((state == HOLD) && (req_sync != req_sync_d) && (OVR_CNT != {CNT_W{1'b1}})) begin
                OVR_CNT <= OVR_CNT + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tgl_handshake_rx.sv
// Directed bench for tgl_handshake_rx with DATA_W=8, SYNC_STAGES=2.
module tb_tgl_handshake_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_tgl = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic       ack_tgl;
`ifdef TGL_RX_OVR_EN
    logic [7:0] ovr_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic ack_exp = 1'b0;

    tgl_handshake_rx #(
        .DATA_W(8),
        .SYNC_STAGES(2)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .REQ_TGL   (req_tgl),
        .DATA_IN   (data_in),
        .DOUT      (dout),
        .DOUT_VALID(dout_valid),
        .DOUT_READY(dout_ready),
        .ACK_TGL   (ack_tgl)
`ifdef TGL_RX_OVR_EN
        ,
        .OVR_CNT   (ovr_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        n_total++;
        if (dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout); else n_pass++;
        n_total++;
        if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dout_valid); else n_pass++;
        n_total++;
        if (ack_tgl !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack_tgl); else n_pass++;
`ifdef TGL_RX_OVR_EN
        n_total++;
        if (ovr_cnt !== 8'h00) $display("FAIL reset_ovr: got %0d want 0", ovr_cnt); else n_pass++;
`endif
        // READY with nothing valid must not produce an ACK
        dout_ready = 1'b1;
        step(3);
        n_total++;
        if (dout_valid !== 1'b0 || ack_tgl !== 1'b0)
            $display("FAIL idle_ready: got valid=%b ack=%b want 0/0", dout_valid, ack_tgl);
        else n_pass++;
    endtask

    task automatic test_single;
        data_in    = 8'hA5;
        req_tgl    = 1'b1;
        dout_ready = 1'b1;
        step(2);
        n_total++;
        if (dout_valid !== 1'b0) $display("FAIL single_early: got valid=%b after edge1 want 0", dout_valid); else n_pass++;
        step(1);
        n_total++;
        if (dout_valid !== 1'b1 || dout !== 8'hA5 || ack_tgl !== 1'b0)
            $display("FAIL single_edge2: got valid=%b dout=%h ack=%b want 1/a5/0", dout_valid, dout, ack_tgl);
        else n_pass++;
        step(1);
        ack_exp = 1'b1;
        n_total++;
        if (dout_valid !== 1'b0 || ack_tgl !== ack_exp)
            $display("FAIL single_edge3: got valid=%b ack=%b want 0/1", dout_valid, ack_tgl);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        data_in    = 8'hA5;
        req_tgl    = 1'b0;
        dout_ready = 1'b0;
        step(3);
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (dout_valid !== 1'b1 || dout !== 8'hA5 || ack_tgl !== ack_exp)
                $display("FAIL bp_hold%0d: got valid=%b dout=%h ack=%b want 1/a5/%b", i, dout_valid, dout, ack_tgl, ack_exp);
            else n_pass++;
            step(1);
        end
        dout_ready = 1'b1;
        step(1);
        ack_exp = ~ack_exp;
        n_total++;
        if (dout_valid !== 1'b0 || ack_tgl !== ack_exp)
            $display("FAIL bp_release: got valid=%b ack=%b want 0/%b", dout_valid, ack_tgl, ack_exp);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [3];
        int hs;
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        hs = 0;
        dout_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            logic       prev_ack;
            logic       got;
            logic [7:0] seen;
            prev_ack = ack_tgl;
            got      = 1'b0;
            seen     = 8'h00;
            data_in  = words[w];
            req_tgl  = ~req_tgl;
            for (int c = 0; c < 12 && !got; c++) begin
                step(1);
                if (dout_valid) begin
                    seen = dout;
                    hs++;
                end
                if (ack_tgl !== prev_ack) got = 1'b1;
            end
            n_total++;
            if (!got || seen !== words[w])
                $display("FAIL b2b_word%0d: got acked=%b dout=%h want 1/%h", w, got, seen, words[w]);
            else n_pass++;
        end
        ack_exp = 1'b1;
        n_total++;
        if (ack_tgl !== ack_exp) $display("FAIL b2b_ack_final: got %b want 1", ack_tgl); else n_pass++;
        n_total++;
        if (hs != 3) $display("FAIL b2b_handshakes: got %0d want 3", hs); else n_pass++;
    endtask

    task automatic test_even_violation;
        data_in    = 8'h77;
        req_tgl    = ~req_tgl;
        dout_ready = 1'b0;
        step(3);
        req_tgl = ~req_tgl;
        step(4);
        req_tgl = ~req_tgl;
        step(4);
        n_total++;
        if (dout_valid !== 1'b1 || dout !== 8'h77)
            $display("FAIL even_hold: got valid=%b dout=%h want 1/77", dout_valid, dout);
        else n_pass++;
        dout_ready = 1'b1;
        step(1);
        ack_exp = ~ack_exp;
        n_total++;
        if (dout_valid !== 1'b0 || ack_tgl !== ack_exp)
            $display("FAIL even_consume: got valid=%b ack=%b want 0/%b", dout_valid, ack_tgl, ack_exp);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1);
            n_total++;
            if (dout_valid !== 1'b0 || ack_tgl !== ack_exp)
                $display("FAIL even_no_extra%0d: got valid=%b ack=%b want 0/%b", i, dout_valid, ack_tgl, ack_exp);
            else n_pass++;
        end
`ifdef TGL_RX_OVR_EN
        n_total++;
        if (ovr_cnt !== 8'd2) $display("FAIL even_ovr: got %0d want 2", ovr_cnt); else n_pass++;
`endif
    endtask

    task automatic test_odd_violation;
        data_in    = 8'h3C;
        req_tgl    = ~req_tgl;
        dout_ready = 1'b0;
        step(3);
        data_in = 8'hC3;
        req_tgl = ~req_tgl;
        step(3);
        n_total++;
        if (dout_valid !== 1'b1 || dout !== 8'h3C)
            $display("FAIL odd_hold: got valid=%b dout=%h want 1/3c", dout_valid, dout);
        else n_pass++;
        dout_ready = 1'b1;
        step(1);
        ack_exp = ~ack_exp;
        n_total++;
        if (dout_valid !== 1'b0 || ack_tgl !== ack_exp)
            $display("FAIL odd_consume: got valid=%b ack=%b want 0/%b", dout_valid, ack_tgl, ack_exp);
        else n_pass++;
        step(1);
        n_total++;
        if (dout_valid !== 1'b1 || dout !== 8'hC3)
            $display("FAIL odd_recapture: got valid=%b dout=%h want 1/c3", dout_valid, dout);
        else n_pass++;
        step(1);
        ack_exp = ~ack_exp;
        n_total++;
        if (dout_valid !== 1'b0 || ack_tgl !== ack_exp)
            $display("FAIL odd_second_ack: got valid=%b ack=%b want 0/%b", dout_valid, ack_tgl, ack_exp);
        else n_pass++;
`ifdef TGL_RX_OVR_EN
        n_total++;
        if (ovr_cnt !== 8'd3) $display("FAIL odd_ovr: got %0d want 3", ovr_cnt); else n_pass++;
`endif
    endtask

    task automatic test_reset_in_hold;
        data_in    = 8'h5A;
        req_tgl    = ~req_tgl;
        dout_ready = 1'b0;
        step(3);
        n_total++;
        if (dout_valid !== 1'b1 || dout !== 8'h5A)
            $display("FAIL rsthold_pre: got valid=%b dout=%h want 1/5a", dout_valid, dout);
        else n_pass++;
        // transmitter is reset in the same window, returning its toggle to 0
        rst     = 1'b1;
        req_tgl = 1'b0;
        step(1);
        ack_exp = 1'b0;
        n_total++;
        if (dout_valid !== 1'b0 || dout !== 8'h00 || ack_tgl !== 1'b0)
            $display("FAIL rsthold_cleared: got valid=%b dout=%h ack=%b want 0/00/0", dout_valid, dout, ack_tgl);
        else n_pass++;
`ifdef TGL_RX_OVR_EN
        n_total++;
        if (ovr_cnt !== 8'd0) $display("FAIL rsthold_ovr: got %0d want 0", ovr_cnt); else n_pass++;
`endif
        step(1);
        rst = 1'b0;
        step(1);
        data_in    = 8'h96;
        req_tgl    = 1'b1;
        dout_ready = 1'b1;
        step(3);
        n_total++;
        if (dout_valid !== 1'b1 || dout !== 8'h96)
            $display("FAIL rsthold_fresh: got valid=%b dout=%h want 1/96", dout_valid, dout);
        else n_pass++;
        step(1);
        ack_exp = 1'b1;
        n_total++;
        if (dout_valid !== 1'b0 || ack_tgl !== ack_exp)
            $display("FAIL rsthold_fresh_ack: got valid=%b ack=%b want 0/1", dout_valid, ack_tgl);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_even_violation();
        test_odd_violation();
        test_reset_in_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
